// File: rtl/spi_target_bridge.sv
// SPI mode-0 target with a small CPU register window (DATA/STATUS).
// SPI pins are oversampled through synchronizers; all logic runs on clk.
module spi_target_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        sck,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [1:0]  ADDR_DATA   = 2'd0;
  localparam logic [1:0]  ADDR_STATUS = 2'd1;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
  logic                   sck_q, cs_q;
  logic [SYNC_STAGES:0]   fill;
  logic                   sel;
  logic [CNT_W-1:0]       bit_cnt;
  logic [BYTE_W-1:0]      rx_shift, tx_shift, rx_data, tx_data;
  logic                   rx_valid, tx_pending, overrun, underrun, frame_err;

  logic              sck_s, mosi_s, cs_s, flushed;
  logic              sck_rise, sck_fall, cs_fall, cs_rise;
  logic              accept, is_write, data_rd, data_wr, status_wr;
  logic              tx_load, byte_done;
  logic [BYTE_W-1:0] tx_next, rx_next;
  logic [DATA_W-1:0] status_word, rd_word;
  logic              unused_bits;

  assign unused_bits = &{1'b0, mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8]};

  // Edge detection on synchronized copies; edges are only trusted once the
  // chain holds real pin samples, so the reset preset never fakes a cs_n fall.
  always_comb begin
    sck_s     = sck_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    cs_s      = cs_sync[SYNC_STAGES-1];
    flushed   = fill[SYNC_STAGES];
    sck_rise  = sel & ~cs_s & sck_s & ~sck_q;
    sck_fall  = sel & ~cs_s & ~sck_s & sck_q;
    cs_fall   = flushed & ~cs_s & cs_q;
    cs_rise   = sel & cs_s & ~cs_q;
    tx_load   = cs_fall | (sck_fall & (bit_cnt == CNT_W'(0)));
    byte_done = sck_rise & (bit_cnt == CNT_W'(7));
    rx_next   = {rx_shift[BYTE_W-2:0], mosi_s};
    tx_next   = tx_pending ? tx_data : 8'hFF;
  end

  // CPU register decode
  always_comb begin
    accept      = mem_valid & ~mem_ready;
    is_write    = |mem_wstrb;
    data_rd     = accept & ~is_write & (mem_addr[3:2] == ADDR_DATA);
    data_wr     = accept & is_write & (mem_addr[3:2] == ADDR_DATA);
    status_wr   = accept & is_write & (mem_addr[3:2] == ADDR_STATUS);
    status_word = {26'b0, ~cs_s, frame_err, underrun, overrun, tx_pending, rx_valid};
    rd_word     = '0;
    case (mem_addr[3:2])
      ADDR_DATA:   rd_word = {24'b0, rx_data};
      ADDR_STATUS: rd_word = status_word;
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sck_sync   <= '0;
      mosi_sync  <= '1;
      cs_sync    <= '1;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      fill       <= '0;
      sel        <= 1'b0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rx_data    <= '0;
      tx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_pending <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      frame_err  <= 1'b0;
      miso       <= 1'b1;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_q     <= sck_s;
      cs_q      <= cs_s;
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};

      mem_ready <= accept;
      if (accept && !is_write) mem_rdata <= rd_word;

      // Frame control and receive shifter
      if (cs_fall) begin
        sel      <= 1'b1;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (cs_rise) begin
        sel      <= 1'b0;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sck_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end

      // Transmit path: boundary loads take priority over plain shifts
      if (tx_load) begin
        miso     <= tx_next[BYTE_W-1];
        tx_shift <= {tx_next[BYTE_W-2:0], 1'b0};
      end else if (sck_fall) begin
        miso     <= tx_shift[BYTE_W-1];
        tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
      end else if (!sel || cs_s) begin
        miso <= 1'b1;
      end

      if (byte_done) rx_data <= rx_next;
      if (byte_done) rx_valid <= 1'b1;
      else if (data_rd) rx_valid <= 1'b0;

      if (data_wr) tx_data <= mem_wdata[BYTE_W-1:0];
      if (data_wr) tx_pending <= 1'b1;
      else if (tx_load) tx_pending <= 1'b0;

      // Sticky flags: a set in the same cycle beats a CPU clear
      overrun   <= (overrun & ~(status_wr & mem_wdata[2])) | (byte_done & rx_valid);
      underrun  <= (underrun & ~(status_wr & mem_wdata[3])) | (tx_load & ~tx_pending);
      frame_err <= (frame_err & ~(status_wr & mem_wdata[4])) |
                   (cs_rise & (bit_cnt != CNT_W'(0)));
    end
  end

endmodule

// File: tb/tb_spi_target_bridge.sv
// Scoreboard bench for spi_target_bridge: CPU reads queue their expected data,
// a monitor pops on every mem_ready; an SPI host task checks miso bytes.
module tb_spi_target_bridge;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        sck, mosi, cs_n, miso;

  int checks = 0;
  int errors = 0;
  int tag    = 0;

  bit          exp_rd_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_tag_q[$];
  bit          mon_rd;
  logic [31:0] mon_data;
  int          mon_tag;

  spi_target_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completion pops one scoreboard entry
  always @(negedge clk) begin
    if (resetn === 1'b1 && mem_ready === 1'b1) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got a completion with no request outstanding");
      end else begin
        mon_rd   = exp_rd_q.pop_front();
        mon_data = exp_data_q.pop_front();
        mon_tag  = exp_tag_q.pop_front();
        if (mon_rd) check($sformatf("read_%0d", mon_tag), mem_rdata, mon_data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit rd, input logic [31:0] d);
    exp_rd_q.push_back(rd);
    exp_data_q.push_back(d);
    exp_tag_q.push_back(tag);
    tag++;
  endtask

  task automatic cpu(input logic [1:0] idx, input logic [3:0] strb,
                     input logic [31:0] wdata, input logic [31:0] exp);
    int n;
    n = 0;
    push_exp(strb == 4'd0, exp);
    mem_addr  = {28'h0, idx, 2'b00};
    mem_wstrb = strb;
    mem_wdata = wdata;
    mem_valid = 1'b1;
    do begin
      cyc(1);
      n++;
    end while (!mem_ready && n < 20);
    mem_valid = 1'b0;
    if (!mem_ready) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout: got no mem_ready within 20 cycles, required one");
    end
  endtask

  task automatic rd(input logic [1:0] idx, input logic [31:0] exp);
    cpu(idx, 4'h0, 32'h0, exp);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    cpu(idx, 4'hF, d, 32'h0);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    cyc(H);
  endtask

  // cs_n rises while sck is still high, then sck returns to idle
  task automatic cs_high();
    cs_n = 1'b1;
    cyc(H);
    sck = 1'b0;
    cyc(H);
  endtask

  // Clock n bits MSB first; hold leaves sck high after the last bit;
  // coincide issues a DATA read in the cycle the last bit completes the byte
  task automatic bits(input logic [7:0] d, input int n, input logic [7:0] exp,
                      input bit hold, input bit coincide, input logic [31:0] rd_exp,
                      input string name);
    logic [7:0] got;
    logic [7:0] mask;
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = d[7-i];
      cyc(H);
      got[7-i] = miso;
      sck = 1'b1;
      if (coincide && i == n - 1) begin
        cyc(2);
        push_exp(1'b1, rd_exp);
        mem_addr  = 32'h0;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        cyc(1);
        check("coincide_ready", {31'b0, mem_ready}, 32'h1);
        mem_valid = 1'b0;
        cyc(H - 3);
      end else begin
        cyc(H);
      end
      if (!(hold && i == n - 1)) sck = 1'b0;
    end
    mask = 8'(8'hFF << (8 - n));
    check(name, {24'b0, got & mask}, {24'b0, exp & mask});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    sck = 1'b0; mosi = 1'b1; cs_n = 1'b1;
    cyc(3);
    check("reset_miso", {31'b0, miso}, 32'h1);
    check("reset_ready", {31'b0, mem_ready}, 32'h0);
    check("reset_rdata", mem_rdata, 32'h0);
    resetn = 1'b1;
    cyc(5);
    rd(2'd1, 32'h00);

    // Loaded TX byte goes out while 0x3C comes in
    wr(2'd0, 32'hA5);
    rd(2'd1, 32'h02);
    cs_low();
    bits(8'h3C, 8, 8'hA5, 1, 0, 0, "miso_a5");
    rd(2'd1, 32'h21);
    rd(2'd0, 32'h3C);
    rd(2'd1, 32'h20);
    cs_high();
    rd(2'd1, 32'h00);
    rd(2'd2, 32'h00);

    // Two bytes with nothing queued: idle fill and underrun
    cs_low();
    bits(8'h5A, 8, 8'hFF, 0, 0, 0, "miso_ff_0");
    bits(8'hC3, 8, 8'hFF, 1, 0, 0, "miso_ff_1");
    rd(2'd1, 32'h2D);
    cs_high();
    rd(2'd1, 32'h0D);
    wr(2'd1, 32'h08);
    rd(2'd1, 32'h05);
    rd(2'd0, 32'hC3);
    rd(2'd1, 32'h04);
    wr(2'd1, 32'h04);
    rd(2'd1, 32'h00);

    // Overrun: second byte replaces the unread first one
    cs_low();
    bits(8'h11, 8, 8'hFF, 0, 0, 0, "miso_ovr_0");
    bits(8'h22, 8, 8'hFF, 1, 0, 0, "miso_ovr_1");
    cs_high();
    rd(2'd1, 32'h0D);
    rd(2'd0, 32'h22);
    wr(2'd1, 32'h1C);
    rd(2'd1, 32'h00);

    // Frame error after 5 bits, then a clean byte
    wr(2'd0, 32'h96);
    cs_low();
    bits(8'hF0, 5, 8'h96, 1, 0, 0, "miso_partial");
    cs_high();
    rd(2'd1, 32'h10);
    wr(2'd0, 32'h4B);
    cs_low();
    bits(8'h69, 8, 8'h4B, 1, 0, 0, "miso_4b");
    cs_high();
    rd(2'd1, 32'h11);
    rd(2'd0, 32'h69);
    wr(2'd1, 32'h10);
    rd(2'd1, 32'h00);

    // DATA read in the byte-completion cycle returns the old byte
    wr(2'd0, 32'h33);
    cs_low();
    bits(8'h81, 8, 8'h33, 0, 0, 0, "miso_33");
    bits(8'h7E, 8, 8'hFF, 1, 1, 32'h81, "miso_coinc");
    rd(2'd1, 32'h2D);
    cs_high();
    rd(2'd0, 32'h7E);
    wr(2'd1, 32'h1C);
    rd(2'd1, 32'h00);

    // Reset mid-byte; sck activity before a fresh cs_n fall is ignored
    wr(2'd0, 32'hC6);
    cs_low();
    bits(8'hFF, 3, 8'hC6, 1, 0, 0, "miso_pre_reset");
    resetn = 1'b0;
    cyc(2);
    check("midreset_miso", {31'b0, miso}, 32'h1);
    check("midreset_ready", {31'b0, mem_ready}, 32'h0);
    check("midreset_rdata", mem_rdata, 32'h0);
    resetn = 1'b1;
    cyc(H);
    bits(8'hAA, 8, 8'hFF, 1, 0, 0, "miso_unselected");
    cs_high();
    rd(2'd1, 32'h00);
    wr(2'd0, 32'h5C);
    cs_low();
    bits(8'hE7, 8, 8'h5C, 1, 0, 0, "miso_5c");
    cs_high();
    rd(2'd1, 32'h01);
    rd(2'd0, 32'hE7);
    rd(2'd1, 32'h00);

    cyc(4);
    check("queue_drained", 32'(exp_rd_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_target_bridge.md
SPI_TARGET_BRIDGE -- requirements
Module: spi_target_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (≥2) on sck, mosi and cs_n.
REQ-002 SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port mem_valid, input, 1: CPU request valid.
REQ-005 SHALL have port mem_addr, input, 32: byte address; only bits [3:2] are decoded.
REQ-006 SHALL have port mem_wdata, input, 32: write data.
REQ-007 SHALL have port mem_wstrb, input, 4: byte strobes; any bit set means write, all zero means read.
REQ-008 SHALL have port mem_ready, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port mem_rdata, output, 32: read data.
REQ-010 SHALL have port sck, input, 1: SPI clock from the external host, asynchronous to clk.
REQ-011 SHALL have port mosi, input, 1: SPI data from the host, asynchronous.
REQ-012 SHALL have port cs_n, input, 1: active-low select from the host, asynchronous.
REQ-013 SHALL have port miso, output, 1: SPI data to the host, driven at all times with no tristate.

Function
REQ-014 SHALL operate in SPI mode 0 with bits MSB first: mosi is sampled on the synchronized sck rise, and miso changes on the synchronized sck fall.
REQ-015 SHALL detect sck and cs_n edges only on the synchronized copies; correct operation requires sck high and low each ≥3 clk cycles.
REQ-016 SHALL, on a synchronized cs_n fall, clear the 3-bit bit counter and load the next TX byte (REQ-020), driving miso from bit 7 of that byte.
REQ-017 SHALL, on each sck rise while selected, shift mosi into rx_shift and increment the bit counter modulo 8.
REQ-018 SHALL, when the counter wraps from 7 to 0, transfer the complete byte to rx_data and set rx_valid; if rx_valid was already 1, it SHALL overwrite rx_data and set the sticky overrun flag.
REQ-019 SHALL, on each sck fall while selected, behave as follows:
- counter ≠ 0: drive miso from tx_shift[7] and shift tx_shift left.
- counter = 0 (byte boundary): load the next TX byte and drive its bit 7.
REQ-020 SHALL form the next TX byte as follows:
- tx_pending = 1: use tx_data and clear tx_pending.
- tx_pending = 0: use 8'hFF and set the sticky underrun flag.
- The load SHALL use the tx_pending value from before the current cycle.
REQ-021 SHALL, on a synchronized cs_n rise with counter ≠ 0, discard the partial byte, clear the counter and set the sticky frame_err flag.
REQ-022 SHALL, whenever synchronized cs_n is high, hold miso at 1 and ignore sck edges.
REQ-023 SHALL accept a CPU request when mem_valid = 1 and mem_ready = 0, assert mem_ready for exactly one cycle on the next edge, and complete no more than one access per request.
REQ-024 SHALL decode the register map on mem_addr[3:2]:
- 0 DATA: a read returns {24'b0, rx_data} and clears rx_valid; a write loads tx_data from mem_wdata[7:0] and sets tx_pending.
- 1 STATUS: a read returns bit0 rx_valid, bit1 tx_pending, bit2 overrun, bit3 underrun, bit4 frame_err, bit5 selected (synchronized cs_n low), all other bits 0.
- 1 STATUS: a write of 1 to bits 2-4 clears the corresponding flags.
- 2 and 3: a read returns 0; a write is ignored.
REQ-025 SHALL update mem_rdata only on reads and hold its last value otherwise.
REQ-026 SHALL give precedence to set over clear when a byte completes in the same cycle as a DATA read: rx_data takes the new byte and rx_valid stays 1.
REQ-027 SHALL give precedence to set over clear when a flag-clearing STATUS write coincides with that flag being set: the flag stays 1.
REQ-028 SHALL, when a DATA write coincides with a TX byte load, load per REQ-020 using the old tx_pending, and leave the new tx_data pending afterwards.
REQ-029 SHALL, when a DATA write occurs while tx_pending = 1, overwrite tx_data with no error flag.

Reset
REQ-030 SHALL, while resetn = 0 at a clk rise, apply the following reset values:
- mem_ready = 0, mem_rdata = 0, miso = 1.
- rx_data = 0, tx_data = 0, shift registers 0, bit counter 0.
- All flags 0.
- Synchronizers preset to the idle levels sck = 0, mosi = 1, cs_n = 1.
REQ-031 SHALL, on reset in the middle of a transfer, abandon the partial byte without setting any flag; after reset is released it SHALL ignore sck edges until a fresh cs_n fall.

Verification
REQ-032 SHALL pass this scenario: CPU writes DATA = 0xA5, then the host sends 0x3C in one frame -> miso carries 1010_0101, rx_data = 0x3C, STATUS = 0x21, and a DATA read returns 0x3C then STATUS = 0x20.
REQ-033 SHALL pass this scenario: the host clocks 2 bytes with no CPU write -> miso = 0xFF for both bytes and STATUS bit3 = 1; writing STATUS 0x08 clears it.
REQ-034 SHALL pass this scenario: the host sends 0x11 then 0x22 with no read -> rx_data = 0x22 and overrun = 1.
REQ-035 SHALL pass this scenario: cs_n rises after 5 bits -> frame_err = 1, rx_valid unchanged, and the next full byte is received correctly.
REQ-036 SHALL pass this scenario: a DATA read lands in the byte-completion cycle -> the returned value is the old byte, and rx_valid = 1 with the new byte in rx_data.
REQ-037 SHALL pass this scenario: resetn is pulsed low mid-byte -> all outputs and status take their reset values, miso = 1, and no flags are set.
